uart_word_assembler: RTL and testbench

Receive-side counterpart of the debug word serializer: gathers the byte stream from the UART receptor (`d_out`/`rx_done`) into 32-bit words for the debug unit. Uses a holding register and a valid/ready handshake towards the consumer. An optional inter-byte timeout discards partial words. Sits between `receptor` and `DebugUnit` and shares the baud-rate `tick`.

---
 rtl/uart_word_assembler.sv | 105 ++++++++++
 tb/tb_uart_word_assembler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// Gathers UART bytes into 32-bit little-endian words with a valid/ready holding register.
// Define UART_WORD_ASSEMBLER_TIMEOUT_EN to enable the inter-byte timeout that discards partial words.
module uart_word_assembler #(
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tick,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [1:0]  byte_count,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state;
  logic [23:0] lanes;
  logic        timeout_hit;

`ifdef UART_WORD_ASSEMBLER_TIMEOUT_EN
  localparam logic [15:0] LAST_TICK = 16'(TIMEOUT_TICKS - 1);

  logic [15:0] idle_count;

  // Fires on the tick that would bring the count to TIMEOUT_TICKS; a byte on the same cycle wins.
  assign timeout_hit = (state == COLLECT) && tick && !rx_done && (idle_count == LAST_TICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_count <= 16'd0;
    end else if (rx_done || (state == IDLE) || timeout_hit) begin
      idle_count <= 16'd0;
    end else if (tick) begin
      idle_count <= idle_count + 16'd1;
    end
  end
`else
  logic [16:0] unused_timeout_inputs;
  assign unused_timeout_inputs = {tick, 16'(TIMEOUT_TICKS)};
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lanes      <= 24'd0;
      byte_count <= 2'd0;
      word_out   <= 32'd0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;

      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (rx_done) begin
        case (state)
          IDLE: begin
            lanes[7:0] <= rx_data;
            byte_count <= 2'd1;
            state      <= COLLECT;
          end
          COLLECT: begin
            case (byte_count)
              2'd1: begin
                lanes[15:8] <= rx_data;
                byte_count  <= 2'd2;
              end
              2'd2: begin
                lanes[23:16] <= rx_data;
                byte_count   <= 2'd3;
              end
              default: begin
                // Holding register is free if empty or being consumed on this same edge.
                if (!word_valid || word_ready) begin
                  word_out   <= {rx_data, lanes};
                  word_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
                byte_count <= 2'd0;
                state      <= IDLE;
              end
            endcase
          end
          default: state <= IDLE;
        endcase
      end else if (timeout_hit) begin
        byte_count <= 2'd0;
        state      <= IDLE;
        timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Self-checking bench for uart_word_assembler: vector table, hand-written corner sequences
// and a randomized phase checked against a byte-queue reference model.
module tb_uart_word_assembler;

  localparam int TT = 8;
`ifdef UART_WORD_ASSEMBLER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tick;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  byte_count;
  logic        overrun;
  logic        timeout;

  uart_word_assembler #(.TIMEOUT_TICKS(TT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tick       (tick),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_count (byte_count),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending bytes of the current word, ticks since the last byte, holding register.
  logic [7:0]  pend[$];
  int          idle_ticks;
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_ovr;
  logic        m_to;

  task automatic model_reset();
    pend.delete();
    idle_ticks = 0;
    m_word = 32'd0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_to = 1'b0;
  endtask

  task automatic model_step(input logic rd, input logic [7:0] d, input logic tk, input logic rdy);
    logic [31:0] w;
    m_ovr = 1'b0;
    m_to = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (rd) begin
      pend.push_back(d);
      idle_ticks = 0;
      if (pend.size() == 4) begin
        w = {pend[3], pend[2], pend[1], pend[0]};
        pend.delete();
        if (!m_valid) begin
          m_word = w;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end else if (pend.size() > 0 && tk) begin
      idle_ticks++;
      if (TO_EN && idle_ticks == TT) begin
        pend.delete();
        idle_ticks = 0;
        m_to = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, ".word_out"},   word_out,          m_word);
    check({name, ".word_valid"}, 32'(word_valid),   32'(m_valid));
    check({name, ".byte_count"}, 32'(byte_count),   32'(pend.size()));
    check({name, ".overrun"},    32'(overrun),      32'(m_ovr));
    check({name, ".timeout"},    32'(timeout),      32'(m_to));
  endtask

  task automatic step(input logic rd, input logic [7:0] d, input logic tk, input logic rdy);
    rx_done = rd;
    rx_data = d;
    tick = tk;
    word_ready = rdy;
    @(posedge clk);
    model_step(rd, d, tk, rdy);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic [7:0]  data;
    logic        rdy;
    logic [31:0] word;
    logic        valid;
    logic [1:0]  cnt;
    logic        ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic [7:0] d, input logic rdy, input logic [31:0] w,
                     input logic v, input logic [1:0] c, input logic o);
    vec_t e;
    e.rd = rd; e.data = d; e.rdy = rdy; e.word = w; e.valid = v; e.cnt = c; e.ovr = o;
    vecs.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tick = 1'b0;
    word_ready = 1'b0;
    model_reset();

    // Single word, consumer always ready.
    add(1, 8'h78, 1, 32'h0,        0, 1, 0);
    add(1, 8'h56, 1, 32'h0,        0, 2, 0);
    add(1, 8'h34, 1, 32'h0,        0, 3, 0);
    add(1, 8'h12, 1, 32'h12345678, 1, 0, 0);
    add(0, 8'h00, 1, 32'h12345678, 0, 0, 0);
    // Two words with consumer stalled: second word is dropped.
    add(1, 8'hAA, 0, 32'h12345678, 0, 1, 0);
    add(1, 8'hBB, 0, 32'h12345678, 0, 2, 0);
    add(1, 8'hCC, 0, 32'h12345678, 0, 3, 0);
    add(1, 8'hDD, 0, 32'hDDCCBBAA, 1, 0, 0);
    add(1, 8'h11, 0, 32'hDDCCBBAA, 1, 1, 0);
    add(1, 8'h22, 0, 32'hDDCCBBAA, 1, 2, 0);
    add(1, 8'h33, 0, 32'hDDCCBBAA, 1, 3, 0);
    add(1, 8'h44, 0, 32'hDDCCBBAA, 1, 0, 1);
    add(0, 8'h00, 0, 32'hDDCCBBAA, 1, 0, 0);
    add(0, 8'h00, 1, 32'hDDCCBBAA, 0, 0, 0);
    // Consume and load on the same edge.
    add(1, 8'h01, 0, 32'hDDCCBBAA, 0, 1, 0);
    add(1, 8'h02, 0, 32'hDDCCBBAA, 0, 2, 0);
    add(1, 8'h03, 0, 32'hDDCCBBAA, 0, 3, 0);
    add(1, 8'h04, 0, 32'h04030201, 1, 0, 0);
    add(1, 8'h05, 0, 32'h04030201, 1, 1, 0);
    add(1, 8'h06, 0, 32'h04030201, 1, 2, 0);
    add(1, 8'h07, 0, 32'h04030201, 1, 3, 0);
    add(1, 8'h08, 1, 32'h08070605, 1, 0, 0);
    add(0, 8'h00, 1, 32'h08070605, 0, 0, 0);

    #12;
    check("reset.word_out",   word_out,         32'h0);
    check("reset.word_valid", 32'(word_valid),  32'h0);
    check("reset.byte_count", 32'(byte_count),  32'h0);
    check("reset.overrun",    32'(overrun),     32'h0);
    check("reset.timeout",    32'(timeout),     32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].data, 1'b0, vecs[i].rdy);
      $display("vec %0d: rd=%0d data=%h rdy=%0d -> word=%h valid=%0d cnt=%0d ovr=%0d",
               i, vecs[i].rd, vecs[i].data, vecs[i].rdy, word_out, word_valid, byte_count, overrun);
      check($sformatf("vec%0d.word_out", i),   word_out,        vecs[i].word);
      check($sformatf("vec%0d.word_valid", i), 32'(word_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.byte_count", i), 32'(byte_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d.overrun", i),    32'(overrun),    32'(vecs[i].ovr));
      check($sformatf("vec%0d.timeout", i),    32'(timeout),    32'h0);
    end

`ifdef UART_WORD_ASSEMBLER_TIMEOUT_EN
    // Partial word abandoned after TT ticks of silence.
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    for (int i = 0; i < TT - 1; i++) begin
      step(0, 8'h00, 1, 1);
      check("to_wait.byte_count", 32'(byte_count), 32'd2);
      check("to_wait.timeout",    32'(timeout),    32'd0);
    end
    step(0, 8'h00, 1, 1);
    check("to_hit.timeout",    32'(timeout),    32'd1);
    check("to_hit.byte_count", 32'(byte_count), 32'd0);
    step(0, 8'h00, 0, 1);
    check("to_after.timeout",  32'(timeout),    32'd0);
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h04, 0, 1);
    check("to_word.word_out",   word_out,        32'h04030201);
    check("to_word.word_valid", 32'(word_valid), 32'd1);
    $display("seq timeout: word=%h", word_out);
    step(0, 8'h00, 0, 1);
    // Third byte arrives on the terminal tick: the byte wins.
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    for (int i = 0; i < TT - 1; i++) step(0, 8'h00, 1, 1);
    step(1, 8'h33, 1, 1);
    check("tie.timeout",    32'(timeout),    32'd0);
    check("tie.byte_count", 32'(byte_count), 32'd3);
    step(0, 8'h00, 0, 1);
    check("tie_after.timeout",    32'(timeout),    32'd0);
    check("tie_after.byte_count", 32'(byte_count), 32'd3);
    step(1, 8'h44, 0, 1);
    check("tie_word.word_out", word_out, 32'h44332211);
    $display("seq tie: word=%h", word_out);
    step(0, 8'h00, 0, 1);
`else
    // Without the timeout a partial word waits indefinitely.
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      step(0, 8'h00, 1, 1);
      check("notimeout.byte_count", 32'(byte_count), 32'd2);
      check("notimeout.timeout",    32'(timeout),    32'd0);
    end
    step(1, 8'hCC, 0, 1);
    step(1, 8'hDD, 0, 1);
    check("notimeout.word_out", word_out, 32'hDDCCBBAA);
    $display("seq no-timeout: word=%h", word_out);
    step(0, 8'h00, 0, 1);
`endif

    // Asynchronous reset mid-word with a word held.
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(1, 8'hA3, 0, 0);
    step(1, 8'hA4, 0, 0);
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 0);
    check("pre_rst.byte_count", 32'(byte_count), 32'd2);
    check("pre_rst.word_valid", 32'(word_valid), 32'd1);
    rx_done = 1'b0;
    rx_data = 8'h00;
    word_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst.word_out",   word_out,        32'h0);
    check("arst.word_valid", 32'(word_valid), 32'h0);
    check("arst.byte_count", 32'(byte_count), 32'h0);
    check("arst.overrun",    32'(overrun),    32'h0);
    check("arst.timeout",    32'(timeout),    32'h0);
    $display("seq async reset: word=%h valid=%0d cnt=%0d", word_out, word_valid, byte_count);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1, 8'hEF, 0, 1);
    step(1, 8'hBE, 0, 1);
    step(1, 8'hAD, 0, 1);
    step(1, 8'hDE, 0, 1);
    check("post_rst.word_out",   word_out,        32'hDEADBEEF);
    check("post_rst.word_valid", 32'(word_valid), 32'd1);
    $display("seq post reset: word=%h", word_out);
    step(0, 8'h00, 0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 2) == 1, ($urandom % 4) != 0);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
